tone_scheduler: RTL and testbench

- Time-multiplexed tone engine for the PSG: one shared compare/increment/toggle datapath serves CHANNELS tone channels (A, B, C).
- Per-channel counter and flip-flop state are held in a small register bank. Each slot walks the bank once per divided-clock tick.
- Replaces three independent tone counters to save area. Per-channel output sequence is identical to a dedicated up-counting tone generator.
- Sits between the clock divider (tick) plus register file (periods, channel resets) and the mixer (out).

---
 rtl/psg_pkg.sv | 31 +++
 rtl/tone_slot_alu.sv | 39 +++
 rtl/tone_scheduler.sv | 173 +++++++++++++++++
 tb/tb_tone_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// ---------------------------------------------------------------------------
// psg_pkg
// Shared definitions for the PSG tone engine.
//   PERIOD_BITS_DEF : default width of a tone period / counter
//   CHANNELS_DEF    : default number of tone channels (A, B, C)
//   COUNT_INIT      : value a tone counter restarts from
//   slotWidth()     : width of a slot index for n channels (never below 1)
//   slot_idx_t      : slot index type for the default channel count
//   sched_state_t   : scheduler FSM states
// ---------------------------------------------------------------------------
package psg_pkg;

  localparam int PERIOD_BITS_DEF = 12;
  localparam int CHANNELS_DEF    = 3;
  localparam int COUNT_INIT      = 1;

  // A single channel still needs a one-bit slot register.
  function automatic int slotWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SLOT_BITS_DEF = slotWidth(CHANNELS_DEF);

  typedef logic [SLOT_BITS_DEF-1:0] slot_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sched_state_t;

endpackage

// File: rtl/tone_slot_alu.sv
// ---------------------------------------------------------------------------
// tone_slot_alu
// Shared compare / increment / toggle step for one tone channel.
// Purely combinational; the scheduler feeds it the channel selected by the
// current slot and writes the results back into that channel's registers.
//   i_count      : current counter of the channel
//   i_period     : channel period (0 behaves like 1)
//   i_state      : current tone flip-flop value
//   o_nextCount  : counter value after this step
//   o_nextState  : flip-flop value after this step
// ---------------------------------------------------------------------------
module tone_slot_alu
  import psg_pkg::*;
#(
  parameter int PERIOD_BITS = PERIOD_BITS_DEF
) (
  input  logic [PERIOD_BITS-1:0] i_count,
  input  logic [PERIOD_BITS-1:0] i_period,
  input  logic                   i_state,
  output logic [PERIOD_BITS-1:0] o_nextCount,
  output logic                   o_nextState
);

  localparam logic [PERIOD_BITS-1:0] INIT = PERIOD_BITS'(COUNT_INIT);

  // Half-wave ends once the counter reaches the period. Because the counter
  // restarts at 1 whenever it reaches a period of at most 2^PERIOD_BITS-1,
  // the increment can never wrap. A zero period is always reached, so it
  // toggles on every step exactly like a period of one.
  always_comb begin
    o_nextCount = i_count + INIT;
    o_nextState = i_state;
    if (i_count >= i_period) begin
      o_nextCount = INIT;
      o_nextState = ~i_state;
    end
  end

endmodule

// File: rtl/tone_scheduler.sv
// ---------------------------------------------------------------------------
// tone_scheduler
// Time-multiplexed tone engine: one tone_slot_alu serves every channel.
// Each tick starts a sweep that visits channel 0..CHANNELS-1, one per clock.
//   i_clk         : system clock
//   i_rst_n       : asynchronous active-low reset
//   i_tick        : one-cycle strobe, requests one count step per channel
//   i_period      : channel i period at [i*PERIOD_BITS +: PERIOD_BITS]
//   i_chan_rst    : per-channel synchronous restart (counter=1, out=1)
//   i_overrun_clr : clears the sticky overrun flag
//   o_out         : tone flip-flop per channel, registered
//   o_busy        : high while a sweep is in progress
//   o_overrun     : sticky, set when a tick had to be dropped
// ---------------------------------------------------------------------------
module tone_scheduler
  import psg_pkg::*;
#(
  parameter int PERIOD_BITS = PERIOD_BITS_DEF,
  parameter int CHANNELS    = CHANNELS_DEF
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_tick,
  input  logic [CHANNELS*PERIOD_BITS-1:0] i_period,
  input  logic [CHANNELS-1:0]             i_chan_rst,
  input  logic                            i_overrun_clr,
  output logic [CHANNELS-1:0]             o_out,
  output logic                            o_busy,
  output logic                            o_overrun
);

  localparam int                     SLOT_W    = slotWidth(CHANNELS);
  localparam logic [SLOT_W-1:0]      LAST_SLOT = SLOT_W'(CHANNELS - 1);
  localparam logic [SLOT_W-1:0]      SLOT_ONE  = SLOT_W'(1);
  localparam logic [PERIOD_BITS-1:0] INIT      = PERIOD_BITS'(COUNT_INIT);

  sched_state_t          r_state;
  sched_state_t          w_nextState;
  logic [SLOT_W-1:0]     r_slot;
  logic [SLOT_W-1:0]     w_nextSlot;
  logic                  r_pending;
  logic                  w_nextPending;
  logic                  w_overrunSet;
  logic                  w_lastSlot;
  logic                  r_overrun;

  logic [PERIOD_BITS-1:0] r_count [CHANNELS];
  logic [CHANNELS-1:0]    r_out;

  logic [PERIOD_BITS-1:0] w_selCount;
  logic [PERIOD_BITS-1:0] w_selPeriod;
  logic                   w_selOut;
  logic [PERIOD_BITS-1:0] w_aluCount;
  logic                   w_aluOut;

  // Operand mux: present the channel addressed by the current slot to the
  // shared ALU. The period is taken live, so a register write lands at the
  // channel's next slot.
  always_comb begin
    w_selCount  = INIT;
    w_selPeriod = '0;
    w_selOut    = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_slot == SLOT_W'(i)) begin
        w_selCount  = r_count[i];
        w_selPeriod = i_period[i*PERIOD_BITS +: PERIOD_BITS];
        w_selOut    = r_out[i];
      end
    end
  end

  tone_slot_alu #(
    .PERIOD_BITS (PERIOD_BITS)
  ) u_alu (
    .i_count     (w_selCount),
    .i_period    (w_selPeriod),
    .i_state     (w_selOut),
    .o_nextCount (w_aluCount),
    .o_nextState (w_aluOut)
  );

  assign w_lastSlot = (r_slot == LAST_SLOT);

  // Sweep sequencing. While busy, one tick can be held as pending; a second
  // one is dropped and flagged. On the last slot the pending request (or a
  // tick arriving right then) restarts the sweep at slot 0. When both are
  // present, the pending one is consumed and the new tick becomes pending.
  always_comb begin
    w_nextState   = r_state;
    w_nextSlot    = r_slot;
    w_nextPending = r_pending;
    w_overrunSet  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_tick) begin
          w_nextState = SWEEP;
          w_nextSlot  = '0;
        end
      end
      SWEEP: begin
        if (w_lastSlot) begin
          w_nextSlot = '0;
          if (r_pending || i_tick) begin
            w_nextState   = SWEEP;
            w_nextPending = r_pending & i_tick;
          end else begin
            w_nextState = IDLE;
          end
        end else begin
          w_nextSlot = r_slot + SLOT_ONE;
          if (i_tick) begin
            if (r_pending) begin
              w_overrunSet = 1'b1;
            end else begin
              w_nextPending = 1'b1;
            end
          end
        end
      end
      default: begin
        w_nextState   = IDLE;
        w_nextSlot    = '0;
        w_nextPending = 1'b0;
      end
    endcase
  end

  // FSM registers and the sticky overrun flag; a new overrun event beats a
  // simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_slot    <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_slot    <= w_nextSlot;
      r_pending <= w_nextPending;
      if (w_overrunSet) begin
        r_overrun <= 1'b1;
      end else if (i_overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // Register bank. A channel restart wins over that channel's slot update in
  // the same cycle and leaves every other channel alone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_count[i] <= INIT;
      end
      r_out <= '1;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (i_chan_rst[i]) begin
          r_count[i] <= INIT;
          r_out[i]   <= 1'b1;
        end else if ((r_state == SWEEP) && (r_slot == SLOT_W'(i))) begin
          r_count[i] <= w_aluCount;
          r_out[i]   <= w_aluOut;
        end
      end
    end
  end

  assign o_out     = r_out;
  assign o_busy    = (r_state == SWEEP);
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_tone_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tone_scheduler
// Directed bench for tone_scheduler (3 channels, 12-bit periods). Inputs are
// driven and outputs sampled on the falling clock edge. Expected tone values
// come from a dedicated per-channel up-counter reference plus hand-derived
// spot values.
// ---------------------------------------------------------------------------
module tb_tone_scheduler;

  localparam int PB = 12;
  localparam int CH = 3;

  logic             clk = 1'b0;
  logic             rstN = 1'b1;
  logic             tick;
  logic [CH*PB-1:0] period;
  logic [CH-1:0]    chanRst;
  logic             overrunClr;
  logic [CH-1:0]    outBits;
  logic             busy;
  logic             overrun;

  int               vectors = 0;
  int               miscompares = 0;

  int               mCount [CH];
  logic [CH-1:0]    mOut;

  tone_scheduler #(
    .PERIOD_BITS (PB),
    .CHANNELS    (CH)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_tick        (tick),
    .i_period      (period),
    .i_chan_rst    (chanRst),
    .i_overrun_clr (overrunClr),
    .o_out         (outBits),
    .o_busy        (busy),
    .o_overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Reference: an independent up-counting tone generator per channel.
  task automatic modelReset();
    for (int i = 0; i < CH; i++) mCount[i] = 1;
    mOut = '1;
  endtask

  task automatic modelChan(input int i);
    if (mCount[i] >= int'(period[i*PB +: PB])) begin
      mCount[i] = 1;
      mOut[i]   = ~mOut[i];
    end else begin
      mCount[i] = mCount[i] + 1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One tick from idle, called at a falling edge. Checks each channel changes
  // exactly one edge after the previous one, and the sweep ends after the
  // last slot. Returns at the falling edge where the next tick may be driven,
  // giving a tick spacing of 4 cycles.
  task automatic applyStimulus(input string tag);
    logic [CH-1:0] exp;
    exp  = mOut;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checkFlag({tag, " busy"}, busy, 1'b1);
    checkOutput({tag, " out before slot0"}, outBits, exp);
    for (int i = 0; i < CH; i++) begin
      modelChan(i);
      exp = mOut;
      @(negedge clk);
      checkOutput({tag, " out after slot"}, outBits, exp);
    end
    checkFlag({tag, " idle"}, busy, 1'b0);
    checkFlag({tag, " no overrun"}, overrun, 1'b0);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    modelReset();
    @(negedge clk);
  endtask

  initial begin
    tick       = 1'b0;
    chanRst    = '0;
    overrunClr = 1'b0;
    period     = {12'd4, 12'd2, 12'd1};
    modelReset();

    // Reset state, before any clock edge
    #1 rstN = 1'b0;
    #1;
    checkOutput("reset out", outBits, 3'b111);
    checkFlag("reset busy", busy, 1'b0);
    checkFlag("reset overrun", overrun, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // A=1, B=2, C=4, 16 ticks spaced 4 cycles
    $display("[TB] periods 1/2/4 tick train");
    for (int k = 1; k <= 16; k++) begin
      applyStimulus("t1");
      if (k == 6) checkOutput("t1 hand after 6 ticks", outBits, 3'b001);
      if (k == 16) checkOutput("t1 hand after 16 ticks", outBits, 3'b111);
    end

    // A=0 must behave as A=1: toggle on every tick
    $display("[TB] period zero");
    doReset();
    period = {12'd4, 12'd2, 12'd0};
    for (int k = 1; k <= 8; k++) begin
      applyStimulus("t2");
      checkFlag("t2 A0 toggles each tick", outBits[0], (k % 2) == 0);
    end

    // Live period changes on channel C
    $display("[TB] period change");
    doReset();
    period = {12'd4, 12'd2, 12'd1};
    applyStimulus("t3");
    applyStimulus("t3");
    period[2*PB +: PB] = 12'd2;
    applyStimulus("t3");
    checkFlag("t3 shorten toggles", outBits[2], 1'b0);
    period[2*PB +: PB] = 12'd8;
    for (int j = 1; j <= 8; j++) begin
      applyStimulus("t3");
      checkFlag("t3 lengthen", outBits[2], j == 8);
    end

    // Ticks 2 cycles apart: back-to-back sweeps, no overrun
    $display("[TB] ticks 2 apart");
    doReset();
    period = {12'd4, 12'd2, 12'd1};
    tick = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      tick = (c == 2);
      checkFlag("t4 busy held", busy, 1'b1);
      checkFlag("t4 overrun clear", overrun, 1'b0);
    end
    @(negedge clk);
    checkFlag("t4 idle", busy, 1'b0);
    for (int t = 0; t < 2; t++) for (int i = 0; i < CH; i++) modelChan(i);
    checkOutput("t4 out after 2 sweeps", outBits, mOut);

    // Ticks 1 cycle apart: third tick is dropped
    $display("[TB] ticks 1 apart");
    tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkFlag("t4b overrun before 3rd", overrun, 1'b0);
    @(negedge clk);
    tick = 1'b0;
    checkFlag("t4b overrun set", overrun, 1'b1);
    repeat (4) @(negedge clk);
    checkFlag("t4b idle", busy, 1'b0);
    checkFlag("t4b overrun sticky", overrun, 1'b1);
    for (int t = 0; t < 2; t++) for (int i = 0; i < CH; i++) modelChan(i);
    checkOutput("t4b out after 2 sweeps", outBits, mOut);
    overrunClr = 1'b1;
    @(negedge clk);
    overrunClr = 1'b0;
    checkFlag("t4b overrun cleared", overrun, 1'b0);

    // chan_rst[1] in channel 1's slot cycle overrides its toggle
    $display("[TB] channel restart");
    doReset();
    period = {12'd4, 12'd3, 12'd1};
    for (int k = 0; k < 4; k++) applyStimulus("t5 pre");
    checkFlag("t5 out1 low before", outBits[1], 1'b0);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    chanRst = 3'b010;
    @(negedge clk);
    chanRst = '0;
    modelChan(0);
    mCount[1] = 1;
    mOut[1]   = 1'b1;
    checkOutput("t5 restart slot1", outBits, mOut);
    modelChan(2);
    @(negedge clk);
    checkOutput("t5 slot2 unaffected", outBits, mOut);
    checkFlag("t5 idle", busy, 1'b0);
    applyStimulus("t5");
    applyStimulus("t5");
    checkFlag("t5 hand after 2 more", outBits[1], 1'b1);
    applyStimulus("t5");
    checkFlag("t5 hand after 3 more", outBits[1], 1'b0);

    // Async reset in the middle of a sweep
    $display("[TB] reset mid-sweep");
    doReset();
    period = {12'd4, 12'd2, 12'd1};
    tick = 1'b1;
    repeat (3) @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);
    checkFlag("t6 overrun primed", overrun, 1'b1);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("t6 async out", outBits, 3'b111);
    checkFlag("t6 async busy", busy, 1'b0);
    checkFlag("t6 async overrun", overrun, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    modelReset();
    repeat (5) begin
      @(negedge clk);
      checkFlag("t6 no resume", busy, 1'b0);
    end
    checkOutput("t6 out held", outBits, 3'b111);
    applyStimulus("t6 fresh");
    checkOutput("t6 hand first tick", outBits, 3'b110);
    applyStimulus("t6 fresh");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
